kamus_lsu_ctrl: RTL and testbench

- Load/store sequencer between the MEM stage and the L1D port.
- Accepts one memory op per L1D access (from `l1d_wr_en` / L_TYPE decode) and drives the L1D req/gnt/rvalid handshake.
- Generates byte enables and lane-aligned write data, and sign/zero-extends load data.
- Stalls the pipeline until the access completes, and handles misalignment and flush.

---
 rtl/kamus_lsu_ctrl_if.sv | 24 ++
 rtl/kamus_lsu_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_kamus_lsu_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kamus_lsu_ctrl_if.sv
// L1D request/response bus seen from the load/store unit.
// The master side (the LSU) drives the request; the slave side (L1D) answers it.
interface kamus_lsu_ctrl_if #(
   parameter int XLEN = 32
);
   logic            l1d_req_o;
   logic            l1d_we_o;
   logic [XLEN-1:0] l1d_addr_o;
   logic [3:0]      l1d_be_o;
   logic [XLEN-1:0] l1d_wdata_o;
   logic            l1d_gnt_i;
   logic            l1d_rvalid_i;
   logic [XLEN-1:0] l1d_rdata_i;

   modport master (
      output l1d_req_o, l1d_we_o, l1d_addr_o, l1d_be_o, l1d_wdata_o,
      input  l1d_gnt_i, l1d_rvalid_i, l1d_rdata_i
   );

   modport slave (
      input  l1d_req_o, l1d_we_o, l1d_addr_o, l1d_be_o, l1d_wdata_o,
      output l1d_gnt_i, l1d_rvalid_i, l1d_rdata_i
   );
endinterface

// File: rtl/kamus_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and the L1D port.
// Optional bus timeout is enabled by defining KAMUS_LSU_TIMEOUT_EN.
module kamus_lsu_ctrl #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mem_valid_i,
   input  logic             mem_we_i,
   input  logic [1:0]       mem_size_i,
   input  logic             mem_unsigned_i,
   input  logic [XLEN-1:0]  mem_addr_i,
   input  logic [XLEN-1:0]  mem_wdata_i,
   input  logic             flush_i,
   kamus_lsu_ctrl_if.master l1d,
   output logic             stall_o,
   output logic             done_o,
   output logic [XLEN-1:0]  load_data_o,
   output logic             misaligned_o,
   output logic             bus_err_o
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]      state_q, state_d;
   logic            req_q, req_d;
   logic            done_q, done_d;
   logic            mis_q, mis_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] ldata_q, ldata_d;
   logic            we_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic [1:0]      off_q;
   logic [XLEN-1:0] addr_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_q;

   logic            accept, misal, launch, tmo;
   logic [1:0]      off;
   logic [3:0]      be_new;
   logic [XLEN-1:0] wdata_new, rd_shift, ld_ext;

   assign off    = mem_addr_i[1:0];
   assign accept = (state_q == S_IDLE) && mem_valid_i && !flush_i;
   assign launch = accept && !misal;

   always_comb begin
      case (mem_size_i)
         2'b00:   misal = 1'b0;
         2'b01:   misal = off[0];
         2'b10:   misal = |off;
         default: misal = 1'b1;
      endcase
   end

   always_comb begin
      be_new    = 4'hF;
      wdata_new = mem_wdata_i;
      case (mem_size_i)
         2'b00: begin
            be_new    = 4'b0001 << off;
            wdata_new = {(XLEN/8){mem_wdata_i[7:0]}};
         end
         2'b01: begin
            be_new    = 4'b0011 << off;
            wdata_new = {(XLEN/16){mem_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend per the latched op.
   assign rd_shift = l1d.l1d_rdata_i >> {off_q, 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   ld_ext = {{(XLEN-8){~uns_q & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_ext = {{(XLEN-16){~uns_q & rd_shift[15]}}, rd_shift[15:0]};
         default: ld_ext = rd_shift;
      endcase
   end

`ifdef KAMUS_LSU_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] cnt_q;

   // REQ is only ever entered from IDLE, so holding the count at zero there clears it on entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (state_q == S_IDLE || state_q == S_DONE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tmo       = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign bus_err_o = err_q;
`else
   logic unused_cfg;
   assign tmo        = 1'b0;
   assign bus_err_o  = 1'b0;
   assign unused_cfg = err_q ^ (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      done_d  = 1'b0;
      mis_d   = 1'b0;
      err_d   = 1'b0;
      ldata_d = ldata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (misal) begin
                  mis_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (l1d.l1d_gnt_i) begin
               req_d = 1'b0;
               if (we_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (l1d.l1d_rvalid_i) begin
                  if (flush_i) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                     ldata_d = ld_ext;
                  end
               end else begin
                  state_d = flush_i ? S_DRAIN : S_WAIT;
               end
            end else if (flush_i) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
            end else if (tmo) begin
               req_d   = 1'b0;
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               ldata_d = '0;
            end
         end
         S_WAIT: begin
            if (l1d.l1d_rvalid_i) begin
               if (flush_i) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  ldata_d = ld_ext;
               end
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end else if (tmo) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               ldata_d = '0;
            end
         end
         S_DRAIN: begin
            if (l1d.l1d_rvalid_i || tmo) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         ldata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         err_q   <= err_d;
         ldata_q <= ldata_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         addr_q  <= '0;
         be_q    <= 4'h0;
         wdata_q <= '0;
      end else if (launch) begin
         we_q    <= mem_we_i;
         size_q  <= mem_size_i;
         uns_q   <= mem_unsigned_i;
         off_q   <= off;
         addr_q  <= {mem_addr_i[XLEN-1:2], 2'b00};
         be_q    <= be_new;
         wdata_q <= wdata_new;
      end
   end

   assign l1d.l1d_req_o   = req_q;
   assign l1d.l1d_we_o    = we_q;
   assign l1d.l1d_addr_o  = addr_q;
   assign l1d.l1d_be_o    = be_q;
   assign l1d.l1d_wdata_o = wdata_q;

   assign stall_o      = launch || (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
   assign done_o       = done_q;
   assign misaligned_o = mis_q;
   assign load_data_o  = ldata_q;
endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Self-checking bench for kamus_lsu_ctrl: directed scenarios plus randomized ops
// checked against an arithmetic model of lanes, extension and latency.
module tb_kamus_lsu_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_we, mem_uns, flush;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        stall, done, mis, berr;
   logic [31:0] ldata;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_ld = 32'h0;

   kamus_lsu_ctrl_if #(.XLEN(32)) bus ();

   kamus_lsu_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .mem_valid_i    (mem_valid),
      .mem_we_i       (mem_we),
      .mem_size_i     (mem_size),
      .mem_unsigned_i (mem_uns),
      .mem_addr_i     (mem_addr),
      .mem_wdata_i    (mem_wdata),
      .flush_i        (flush),
      .l1d            (bus.master),
      .stall_o        (stall),
      .done_o         (done),
      .load_data_o    (ldata),
      .misaligned_o   (mis),
      .bus_err_o      (berr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic bit m_misal(input logic [1:0] sz, input logic [31:0] addr);
      if (sz == 2'b11) return 1'b1;
      return (addr % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
      int v;
      v = ((1 << nbytes(sz)) - 1) << (addr % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
      if (sz == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
      if (sz == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                          input logic [1:0] sz, input bit uns);
      longint unsigned v, span;
      span = 64'd1 << (8 * nbytes(sz));
      v    = (longint'({32'h0, rd}) >> (8 * (addr % 4))) % span;
      if (!uns && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'b10; mem_uns = 1'b0;
      mem_addr = 32'h0; mem_wdata = 32'h0; flush = 1'b0;
      bus.l1d_gnt_i = 1'b0; bus.l1d_rvalid_i = 1'b0; bus.l1d_rdata_i = 32'h0;
   endtask

   // One complete aligned op, gnt after gnt_dly REQ cycles, rvalid rv_dly cycles after gnt.
   task automatic run_op(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rd, input bit flush_at_gnt);
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_addr;
      int          stalls, e_stalls;
      e_be   = m_be(sz, addr);
      e_wd   = (sz == 2'b10) ? wd : m_wdata(sz, wd);
      e_addr = addr & 32'hFFFF_FFFC;
      stalls = 0;
      mem_valid = 1'b1; mem_we = we; mem_size = sz; mem_uns = uns;
      mem_addr = addr; mem_wdata = wd; flush = 1'b0;
      bus.l1d_gnt_i = 1'b0; bus.l1d_rvalid_i = 1'b0;
      #1;
      n_vec++;
      if ({stall, done} !== 2'b10) begin
         n_err++;
         $display("FAIL accept: stall/done got %b required 10 (addr=%h)", {stall, done}, addr);
      end
      stalls += int'(stall);
      tick();
      for (int i = 0; i <= gnt_dly; i++) begin
         bus.l1d_gnt_i    = (i == gnt_dly);
         bus.l1d_rvalid_i = (!we && rv_dly == 0 && i == gnt_dly);
         bus.l1d_rdata_i  = rd;
         flush            = flush_at_gnt && (i == gnt_dly);
         #1;
         n_vec++;
         if ({bus.l1d_req_o, bus.l1d_we_o, bus.l1d_addr_o, bus.l1d_be_o, bus.l1d_wdata_o, mis, done}
             !== {1'b1, we, e_addr, e_be, e_wd, 2'b00}) begin
            n_err++;
            $display("FAIL req_hold[%0d]: req=%b we=%b addr=%h be=%b wdata=%h mis=%b done=%b required req=1 we=%b addr=%h be=%b wdata=%h mis=0 done=0",
                     i, bus.l1d_req_o, bus.l1d_we_o, bus.l1d_addr_o, bus.l1d_be_o, bus.l1d_wdata_o,
                     mis, done, we, e_addr, e_be, e_wd);
         end
         stalls += int'(stall);
         tick();
      end
      bus.l1d_gnt_i = 1'b0; bus.l1d_rvalid_i = 1'b0; flush = 1'b0;
      if (!we) begin
         for (int j = 1; j <= rv_dly; j++) begin
            bus.l1d_rvalid_i = (j == rv_dly);
            #1;
            n_vec++;
            if ({bus.l1d_req_o, done} !== 2'b00) begin
               n_err++;
               $display("FAIL wait[%0d]: req/done got %b required 00", j, {bus.l1d_req_o, done});
            end
            stalls += int'(stall);
            tick();
         end
         bus.l1d_rvalid_i = 1'b0;
         exp_ld = m_load(rd, addr, sz, uns);
      end
      #1;
      n_vec++;
      if ({done, stall, bus.l1d_req_o, berr} !== 4'b1000) begin
         n_err++;
         $display("FAIL done_pulse: done/stall/req/berr got %b required 1000", {done, stall, bus.l1d_req_o, berr});
      end
      n_vec++;
      if (ldata !== exp_ld) begin
         n_err++;
         $display("FAIL load_data: got %h required %h", ldata, exp_ld);
      end
      e_stalls = 2 + gnt_dly + (we ? 0 : rv_dly);
      n_vec++;
      if (stalls !== e_stalls) begin
         n_err++;
         $display("FAIL stall_count: got %0d cycles required %0d", stalls, e_stalls);
      end
      $display("op %s sz=%0d uns=%0d addr=%h wdata=%h rdata=%h gnt_dly=%0d rv_dly=%0d ldata=%h",
               we ? "ST" : "LD", sz, uns, addr, wd, rd, gnt_dly, rv_dly, ldata);
      tick();
      mem_valid = 1'b0;
   endtask

   task automatic misaligned_op(input logic [1:0] sz, input logic [31:0] addr);
      mem_valid = 1'b1; mem_we = 1'b0; mem_size = sz; mem_addr = addr; flush = 1'b0;
      #1;
      n_vec++;
      if (stall !== 1'b0) begin
         n_err++;
         $display("FAIL misal_stall: got %b required 0", stall);
      end
      tick();
      mem_valid = 1'b0;
      #1;
      n_vec++;
      if ({mis, bus.l1d_req_o, stall} !== 3'b100) begin
         n_err++;
         $display("FAIL misal_pulse: mis/req/stall got %b required 100", {mis, bus.l1d_req_o, stall});
      end
      $display("op MISALIGNED sz=%0d addr=%h", sz, addr);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      n_vec++;
      if ({bus.l1d_req_o, bus.l1d_we_o, bus.l1d_addr_o, bus.l1d_be_o, bus.l1d_wdata_o,
           stall, done, ldata, mis, berr} !== '0) begin
         n_err++;
         $display("FAIL reset: req=%b be=%b addr=%h stall=%b done=%b ldata=%h mis=%b berr=%b required all 0",
                  bus.l1d_req_o, bus.l1d_be_o, bus.l1d_addr_o, stall, done, ldata, mis, berr);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_ld = 32'h0;
      tick();
   endtask

   task automatic test_load_word();
      run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0);
      n_vec++;
      if ({ldata, bus.l1d_be_o} !== {32'hDEAD_BEEF, 4'hF}) begin
         n_err++;
         $display("FAIL lw_result: ldata=%h be=%b required DEADBEEF/1111", ldata, bus.l1d_be_o);
      end
   endtask

   task automatic test_load_byte();
      run_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 0, 1, 32'h8011_2233, 1'b0);
      n_vec++;
      if ({ldata, bus.l1d_be_o} !== {32'hFFFF_FF80, 4'b1000}) begin
         n_err++;
         $display("FAIL lb_result: ldata=%h be=%b required FFFFFF80/1000", ldata, bus.l1d_be_o);
      end
      run_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1, 2, 32'h8011_2233, 1'b0);
      n_vec++;
      if (ldata !== 32'h0000_0080) begin
         n_err++;
         $display("FAIL lbu_result: ldata=%h required 00000080", ldata);
      end
   endtask

   task automatic test_store_half();
      run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_ABCD, 3, 0, 32'h0, 1'b0);
      n_vec++;
      if ({bus.l1d_be_o, bus.l1d_wdata_o, bus.l1d_addr_o} !== {4'b1100, 32'hABCD_ABCD, 32'h100}) begin
         n_err++;
         $display("FAIL sh_lanes: be=%b wdata=%h addr=%h required 1100/ABCDABCD/00000100",
                  bus.l1d_be_o, bus.l1d_wdata_o, bus.l1d_addr_o);
      end
   endtask

   task automatic test_misaligned();
      misaligned_op(2'b10, 32'h101);
      run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'h1234_5678, 0, 0, 32'h0, 1'b0);
      misaligned_op(2'b11, 32'h200);
      misaligned_op(2'b01, 32'h203);
   endtask

   task automatic test_flush();
      // flush while waiting for read data; the late rvalid must be swallowed
      run_op_accept_load(32'h300);
      bus.l1d_gnt_i = 1'b1;
      tick();
      bus.l1d_gnt_i = 1'b0; flush = 1'b1; mem_valid = 1'b0;
      #1;
      n_vec++;
      if ({stall, done} !== 2'b10) begin
         n_err++;
         $display("FAIL flush_wait: stall/done got %b required 10", {stall, done});
      end
      tick();
      flush = 1'b0;
      tick();
      bus.l1d_rvalid_i = 1'b1; bus.l1d_rdata_i = $urandom;
      #1;
      n_vec++;
      if ({stall, done, bus.l1d_req_o} !== 3'b100) begin
         n_err++;
         $display("FAIL drain: stall/done/req got %b required 100", {stall, done, bus.l1d_req_o});
      end
      tick();
      bus.l1d_rvalid_i = 1'b0;
      #1;
      n_vec++;
      if ({stall, done, ldata} !== {2'b00, exp_ld}) begin
         n_err++;
         $display("FAIL drain_exit: stall=%b done=%b ldata=%h required 0/0/%h", stall, done, ldata, exp_ld);
      end
      $display("op LD flushed in WAIT, rvalid drained");
      run_op(1'b0, 2'b01, 1'b0, 32'h306, 32'h0, 0, 1, 32'h9ABC_1234, 1'b0);

      // flush in REQ before gnt: request withdrawn, no completion
      mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h310;
      tick();
      flush = 1'b1; mem_valid = 1'b0;
      tick();
      flush = 1'b0;
      #1;
      n_vec++;
      if ({bus.l1d_req_o, stall, done} !== 3'b000) begin
         n_err++;
         $display("FAIL flush_req: req/stall/done got %b required 000", {bus.l1d_req_o, stall, done});
      end
      $display("op ST flushed in REQ");

      // flush in IDLE: request never accepted
      mem_valid = 1'b1; flush = 1'b1;
      #1;
      n_vec++;
      if (stall !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_stall: got %b required 0", stall);
      end
      tick();
      mem_valid = 1'b0; flush = 1'b0;
      #1;
      n_vec++;
      if (bus.l1d_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_req: got %b required 0", bus.l1d_req_o);
      end
      $display("op ST flushed in IDLE");

      // flush coincident with a store grant: the store still commits
      run_op(1'b1, 2'b00, 1'b0, 32'h321, 32'h0000_00A5, 1, 0, 32'h0, 1'b1);
   endtask

   task automatic run_op_accept_load(input logic [31:0] addr);
      mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_uns = 1'b0; mem_addr = addr; flush = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
`ifdef KAMUS_LSU_TIMEOUT_EN
      run_op_accept_load(32'h400);
      for (int i = 1; i <= 8; i++) begin
         #1;
         n_vec++;
         if ({bus.l1d_req_o, done} !== 2'b10) begin
            n_err++;
            $display("FAIL tmo_req[%0d]: req/done got %b required 10", i, {bus.l1d_req_o, done});
         end
         tick();
      end
      exp_ld = 32'h0;
      n_vec++;
      if ({done, berr, bus.l1d_req_o, ldata} !== {3'b110, 32'h0}) begin
         n_err++;
         $display("FAIL tmo_done: done=%b berr=%b req=%b ldata=%h required 1/1/0/0", done, berr, bus.l1d_req_o, ldata);
      end
      mem_valid = 1'b0;
      tick();
      bus.l1d_rvalid_i = 1'b1;
      tick();
      bus.l1d_rvalid_i = 1'b0;
      n_vec++;
      if ({done, berr, stall} !== 3'b000) begin
         n_err++;
         $display("FAIL tmo_late: done/berr/stall got %b required 000", {done, berr, stall});
      end
      $display("op LD timed out");
`else
      mem_valid = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h400;
      tick();
      mem_valid = 1'b0;
      repeat (20) tick();
      n_vec++;
      if ({bus.l1d_req_o, berr, done} !== 3'b100) begin
         n_err++;
         $display("FAIL no_tmo: req/berr/done got %b required 100", {bus.l1d_req_o, berr, done});
      end
      bus.l1d_gnt_i = 1'b1;
      tick();
      bus.l1d_gnt_i = 1'b0;
      n_vec++;
      if ({done, berr} !== 2'b10) begin
         n_err++;
         $display("FAIL no_tmo_done: done/berr got %b required 10", {done, berr});
      end
      $display("op ST long grant wait");
      tick();
`endif
   endtask

   task automatic test_async_reset();
      run_op_accept_load(32'h500);
      bus.l1d_gnt_i = 1'b1;
      tick();
      bus.l1d_gnt_i = 1'b0; mem_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({bus.l1d_req_o, bus.l1d_be_o, bus.l1d_addr_o, stall, done, ldata, mis, berr} !== '0) begin
         n_err++;
         $display("FAIL async_reset: req=%b be=%b stall=%b done=%b ldata=%h required all 0",
                  bus.l1d_req_o, bus.l1d_be_o, stall, done, ldata);
      end
      exp_ld = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      $display("op LD reset in WAIT");
      run_op(1'b0, 2'b10, 1'b0, 32'h504, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [1:0]  sz;
      logic [31:0] addr;
      for (int k = 0; k < 40; k++) begin
         sz   = 2'($urandom_range(0, 3));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) addr = (addr / nbytes(sz)) * nbytes(sz);
         if (m_misal(sz, addr)) begin
            misaligned_op(sz, addr);
         end else begin
            run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_flush();
      test_timeout();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
